mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter WDOG_CYCLES, default 64, the number of BUSY cycles after which the watchdog trips (MEM_WATCHDOG_EN builds only).
REQ-002 CLK  input  1  system clock; all state SHALL update on the rising edge.
REQ-003 nRST  input  1  reset, asynchronous and active-low.
REQ-004 ihit  input  1  instruction fetch complete; gates pipeline advance.
REQ-005 flush  input  1  replaces the MEM/WB contents with a bubble on the next advance.
REQ-006 in_RegWr, in_MemToReg, in_MemRead, in_MemWrite, in_Branch, in_beq, in_bne, in_jump, in_jr, in_jal, in_lui, in_halt, in_zero  input  1 each  EX/MEM control outputs.
REQ-007 in_rdat1, in_rdat2, in_PortOut, in_npc, in_JumpAddr, in_BranchAddr, in_instr  input  32 each  EX/MEM data outputs (in_PortOut is the ALU result and memory address).
REQ-008 in_wsel  input  5  destination register.
REQ-009 dhit  input  1  data cache done; dmemload  input  32  load data.
REQ-010 dmemREN, dmemWEN  output  1 each; dmemaddr, dmemstore  output  32 each  data cache request.
REQ-011 mem_stall  output  1  holds the PC, IF/ID, ID/EX and EX/MEM registers.
REQ-012 pc_redirect  output  1; redirect_pc  output  32  control-transfer resolution.
REQ-013 wb_RegWr, wb_MemToReg, wb_halt, wb_jal  output  1 each; wb_wsel  output  5; wb_result, wb_load, wb_npc, wb_instr  output  32 each  MEM/WB register.
REQ-014 mem_timeout  output  1  sticky watchdog flag.

Function
REQ-015 mem_op = in_MemRead | in_MemWrite; FSM states IDLE, BUSY, HOLD.
REQ-016 IDLE: if mem_op and no dhit -> BUSY; if mem_op and dhit and no ihit -> HOLD; otherwise stay in IDLE.
REQ-017 BUSY: on dhit with ihit -> IDLE; on dhit without ihit -> HOLD; otherwise stay in BUSY.
REQ-018 HOLD: on ihit -> IDLE.
REQ-019 dmemREN = in_MemRead and dmemWEN = in_MemWrite in IDLE and BUSY, both 0 in HOLD; dmemaddr = in_PortOut; dmemstore = in_rdat2.
REQ-020 dmemload SHALL be captured into a hold register on the dhit cycle; in HOLD, wb_load is sourced from the hold register.
REQ-021 mem_stall = mem_op & ~dhit & (state != HOLD).
REQ-022 advance = ihit & ~mem_stall; MEM/WB updates only on advance, otherwise holds its value.
REQ-023 On advance with flush = 1, MEM/WB SHALL load a bubble (all fields 0), with flush taking priority over the incoming data.
REQ-024 wb_result = {in_instr[15:0], 16'h0} when in_lui, otherwise in_PortOut; wb_load = dmemload (or the hold register).
REQ-025 taken = in_Branch & ((in_beq & in_zero) | (in_bne & ~in_zero)).
REQ-026 pc_redirect = taken | in_jump | in_jr, combinational.
REQ-027 redirect_pc priority is jr -> in_rdat1, then jump -> in_JumpAddr, then branch -> in_BranchAddr; 0 when there is no redirect.
REQ-028 wb_halt SHALL be sticky: once it latches 1 it stays 1 until reset; flush does not clear it.
REQ-029 While wb_halt = 1, dmemREN and dmemWEN SHALL be forced to 0.
REQ-030 Load latency: 1 cycle from dhit to the MEM/WB update, given ihit.

Reset
REQ-031 nRST low SHALL asynchronously set the FSM to IDLE and clear all MEM/WB outputs, the hold register, the watchdog counter and mem_timeout to 0.
REQ-032 Reset asserted mid-BUSY SHALL abandon the request; dmemREN and dmemWEN reflect the inputs in IDLE after release.

Configuration
REQ-033 With MEM_WATCHDOG_EN defined: a counter increments every BUSY cycle and clears on leaving BUSY; mem_timeout sets when the count reaches WDOG_CYCLES-1 and stays set until reset.
REQ-034 Without MEM_WATCHDOG_EN: mem_timeout is tied to 0 and no counter is built.

Verification
REQ-035 lw, addr 0x100, dhit on the 3rd cycle, ihit = 1 -> mem_stall high for 2 cycles; wb_load = 0xDEADBEEF next edge.
REQ-036 sw, in_rdat2 = 0x12345678, dhit with ihit = 0 for 2 cycles -> HOLD; dmemWEN drops; MEM/WB updates on ihit.
REQ-037 beq with in_zero = 1, in_BranchAddr = 0x40 -> pc_redirect = 1 and redirect_pc = 0x40; with in_zero = 0 -> pc_redirect = 0.
REQ-038 flush plus advance -> all wb_* = 0; a prior wb_halt = 1 stays 1.
REQ-039 nRST pulsed low during BUSY -> all outputs 0 asynchronously; state IDLE.
REQ-040 MEM_WATCHDOG_EN with WDOG_CYCLES = 8 and dhit never asserted -> mem_timeout = 1 after the 8th BUSY cycle.

Source files
------------

// File: rtl/mem_stage_if.sv
// Data-cache request/response bundle between the MEM stage (master) and the data cache (slave).
interface mem_stage_if;
  logic        dmemREN;
  logic        dmemWEN;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic        dhit;
  logic [31:0] dmemload;

  modport master (
    output dmemREN, dmemWEN, dmemaddr, dmemstore,
    input  dhit, dmemload
  );

  modport slave (
    input  dmemREN, dmemWEN, dmemaddr, dmemstore,
    output dhit, dmemload
  );
endinterface

// File: rtl/mem_stage.sv
// Pipeline MEM stage: data-cache handshake FSM, control-transfer resolution and the MEM/WB register.
// Optional busy watchdog is built only when MEM_WATCHDOG_EN is defined.
module mem_stage #(
   parameter int WDOG_CYCLES = 64
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        ihit,
   input  logic        flush,
   input  logic        in_RegWr,
   input  logic        in_MemToReg,
   input  logic        in_MemRead,
   input  logic        in_MemWrite,
   input  logic        in_Branch,
   input  logic        in_beq,
   input  logic        in_bne,
   input  logic        in_jump,
   input  logic        in_jr,
   input  logic        in_jal,
   input  logic        in_lui,
   input  logic        in_halt,
   input  logic        in_zero,
   input  logic [31:0] in_rdat1,
   input  logic [31:0] in_rdat2,
   input  logic [31:0] in_PortOut,
   input  logic [31:0] in_npc,
   input  logic [31:0] in_JumpAddr,
   input  logic [31:0] in_BranchAddr,
   input  logic [31:0] in_instr,
   input  logic [4:0]  in_wsel,
   mem_stage_if.master dbus,
   output logic        mem_stall,
   output logic        pc_redirect,
   output logic [31:0] redirect_pc,
   output logic        wb_RegWr,
   output logic        wb_MemToReg,
   output logic        wb_halt,
   output logic        wb_jal,
   output logic [4:0]  wb_wsel,
   output logic [31:0] wb_result,
   output logic [31:0] wb_load,
   output logic [31:0] wb_npc,
   output logic [31:0] wb_instr,
   output logic        mem_timeout
);

   typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

   if (WDOG_CYCLES < 1) begin : g_bad_wdog
      $error("WDOG_CYCLES must be at least 1");
   end

   state_t      state_q, state_d;
   logic        mem_op;
   logic        advance;
   logic        taken;
   logic [31:0] load_hold_q;
   logic [31:0] load_src;
   logic [31:0] result_d;

   assign mem_op = in_MemRead | in_MemWrite;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // NOTE: every output of this block is given a default first, so no path can infer a latch.
   always_comb begin
      state_d        = state_q;
      mem_stall      = 1'b0;
      dbus.dmemREN   = 1'b0;
      dbus.dmemWEN   = 1'b0;
      dbus.dmemaddr  = in_PortOut;
      dbus.dmemstore = in_rdat2;

      unique case (state_q)
         IDLE: begin
            if (mem_op && !dbus.dhit)              state_d = BUSY;
            else if (mem_op && dbus.dhit && !ihit) state_d = HOLD;
         end
         BUSY: begin
            if (dbus.dhit) state_d = ihit ? IDLE : HOLD;
         end
         HOLD: begin
            if (ihit) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // HOLD has already been served by the cache; a halted core issues nothing further.
      if (state_q != HOLD && !wb_halt) begin
         dbus.dmemREN = in_MemRead;
         dbus.dmemWEN = in_MemWrite;
      end

      mem_stall = mem_op & ~dbus.dhit & (state_q != HOLD);
   end

   assign advance = ihit & ~mem_stall;

   // Load data must survive the HOLD wait, since the cache drops dmemload after dhit.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)                                   load_hold_q <= '0;
      else if (mem_op && dbus.dhit && state_q != HOLD) load_hold_q <= dbus.dmemload;
   end

   assign load_src = (state_q == HOLD) ? load_hold_q : dbus.dmemload;
   assign result_d = in_lui ? {in_instr[15:0], 16'h0000} : in_PortOut;

   always_comb begin
      taken       = in_Branch & ((in_beq & in_zero) | (in_bne & ~in_zero));
      pc_redirect = taken | in_jump | in_jr;
      redirect_pc = '0;
      if (in_jr)        redirect_pc = in_rdat1;
      else if (in_jump) redirect_pc = in_JumpAddr;
      else if (taken)   redirect_pc = in_BranchAddr;
   end

   // MEM/WB register; halt is sticky and ignores flush.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         wb_RegWr    <= 1'b0;
         wb_MemToReg <= 1'b0;
         wb_halt     <= 1'b0;
         wb_jal      <= 1'b0;
         wb_wsel     <= '0;
         wb_result   <= '0;
         wb_load     <= '0;
         wb_npc      <= '0;
         wb_instr    <= '0;
      end else if (advance) begin
         wb_halt <= wb_halt | (in_halt & ~flush);
         if (flush) begin
            wb_RegWr    <= 1'b0;
            wb_MemToReg <= 1'b0;
            wb_jal      <= 1'b0;
            wb_wsel     <= '0;
            wb_result   <= '0;
            wb_load     <= '0;
            wb_npc      <= '0;
            wb_instr    <= '0;
         end else begin
            wb_RegWr    <= in_RegWr;
            wb_MemToReg <= in_MemToReg;
            wb_jal      <= in_jal;
            wb_wsel     <= in_wsel;
            wb_result   <= result_d;
            wb_load     <= load_src;
            wb_npc      <= in_npc;
            wb_instr    <= in_instr;
         end
      end
   end

`ifdef MEM_WATCHDOG_EN
   localparam int CNT_W = $clog2(WDOG_CYCLES) + 1;

   logic [CNT_W-1:0] wdog_cnt_q;
   logic             timeout_q;

   // Counter saturates so a stuck request cannot wrap it back below the trip point.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         wdog_cnt_q <= '0;
         timeout_q  <= 1'b0;
      end else if (state_q == BUSY) begin
         if (wdog_cnt_q == CNT_W'(WDOG_CYCLES - 1)) timeout_q <= 1'b1;
         if (wdog_cnt_q != '1)                        wdog_cnt_q <= wdog_cnt_q + CNT_W'(1);
      end else begin
         wdog_cnt_q <= '0;
      end
   end

   assign mem_timeout = timeout_q;
`else
   assign mem_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: redirect/result vector table plus cache-handshake sequences.
module tb_mem_stage;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        ihit, flush;
   logic        in_RegWr, in_MemToReg, in_MemRead, in_MemWrite, in_Branch, in_beq, in_bne;
   logic        in_jump, in_jr, in_jal, in_lui, in_halt, in_zero;
   logic [31:0] in_rdat1, in_rdat2, in_PortOut, in_npc, in_JumpAddr, in_BranchAddr, in_instr;
   logic [4:0]  in_wsel;
   logic        mem_stall, pc_redirect;
   logic [31:0] redirect_pc;
   logic        wb_RegWr, wb_MemToReg, wb_halt, wb_jal;
   logic [4:0]  wb_wsel;
   logic [31:0] wb_result, wb_load, wb_npc, wb_instr;
   logic        mem_timeout;

   int checks   = 0;
   int failures = 0;

`ifdef MEM_WATCHDOG_EN
   localparam bit WDOG_ON = 1'b1;
`else
   localparam bit WDOG_ON = 1'b0;
`endif

   mem_stage_if bus ();

   mem_stage #(.WDOG_CYCLES(8)) dut (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .flush(flush),
      .in_RegWr(in_RegWr), .in_MemToReg(in_MemToReg), .in_MemRead(in_MemRead),
      .in_MemWrite(in_MemWrite), .in_Branch(in_Branch), .in_beq(in_beq), .in_bne(in_bne),
      .in_jump(in_jump), .in_jr(in_jr), .in_jal(in_jal), .in_lui(in_lui), .in_halt(in_halt),
      .in_zero(in_zero), .in_rdat1(in_rdat1), .in_rdat2(in_rdat2), .in_PortOut(in_PortOut),
      .in_npc(in_npc), .in_JumpAddr(in_JumpAddr), .in_BranchAddr(in_BranchAddr),
      .in_instr(in_instr), .in_wsel(in_wsel), .dbus(bus.master),
      .mem_stall(mem_stall), .pc_redirect(pc_redirect), .redirect_pc(redirect_pc),
      .wb_RegWr(wb_RegWr), .wb_MemToReg(wb_MemToReg), .wb_halt(wb_halt), .wb_jal(wb_jal),
      .wb_wsel(wb_wsel), .wb_result(wb_result), .wb_load(wb_load), .wb_npc(wb_npc),
      .wb_instr(wb_instr), .mem_timeout(mem_timeout)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic        branch, beq, bne, zero, jump, jr, lui;
      logic [31:0] rdat1, jaddr, baddr, port_out, instr;
      logic        exp_redirect;
      logic [31:0] exp_pc, exp_result;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic clear_inputs();
      ihit = 1'b0; flush = 1'b0;
      in_RegWr = 1'b0; in_MemToReg = 1'b0; in_MemRead = 1'b0; in_MemWrite = 1'b0;
      in_Branch = 1'b0; in_beq = 1'b0; in_bne = 1'b0; in_jump = 1'b0; in_jr = 1'b0;
      in_jal = 1'b0; in_lui = 1'b0; in_halt = 1'b0; in_zero = 1'b0;
      in_rdat1 = '0; in_rdat2 = '0; in_PortOut = '0; in_npc = '0;
      in_JumpAddr = '0; in_BranchAddr = '0; in_instr = '0; in_wsel = '0;
      bus.dhit = 1'b0; bus.dmemload = '0;
   endtask

   task automatic check_wb_zero(input string tag);
      check({tag, "_wb_RegWr"},    wb_RegWr,    0);
      check({tag, "_wb_MemToReg"}, wb_MemToReg, 0);
      check({tag, "_wb_jal"},      wb_jal,      0);
      check({tag, "_wb_wsel"},     wb_wsel,     0);
      check({tag, "_wb_result"},   wb_result,   0);
      check({tag, "_wb_load"},     wb_load,     0);
      check({tag, "_wb_npc"},      wb_npc,      0);
      check({tag, "_wb_instr"},    wb_instr,    0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1, "simulation time limit");
   end

   initial begin
      //              br    beq   bne   zero  jump  jr    lui   rdat1         jaddr         baddr         port          instr         redir exp_pc        exp_result
      vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h40, 32'h11, 32'h0,        1'b1, 32'h40,       32'h11};
      vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h40, 32'h22, 32'h0,        1'b0, 32'h0,        32'h22};
      vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h80, 32'h33, 32'h0,        1'b1, 32'h80,       32'h33};
      vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h80, 32'h44, 32'h0,        1'b0, 32'h0,        32'h44};
      vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h40, 32'h55, 32'h0,        1'b0, 32'h0,        32'h55};
      vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        32'h1000,     32'h40, 32'h66, 32'h0,        1'b1, 32'h1000,     32'h66};
      vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h2000,     32'h1000,     32'h0,  32'h77, 32'h0,        1'b1, 32'h2000,     32'h77};
      vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        32'h0,        32'h0,  32'h55, 32'h3C01ABCD, 1'b0, 32'h0,        32'hABCD0000};
      vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFC, 32'h0,        32'h0,  32'h0,  32'h0,        1'b1, 32'hFFFFFFFC, 32'h0};

      // Reset state
      clear_inputs();
      nRST = 1'b0;
      #12;
      check_wb_zero("reset");
      check("reset_wb_halt",     wb_halt,     0);
      check("reset_mem_timeout", mem_timeout, 0);
      check("reset_mem_stall",   mem_stall,   0);
      nRST = 1'b1;
      tick();

      // Redirect resolution and result selection
      for (int i = 0; i < 9; i++) begin
         clear_inputs();
         ihit = 1'b1; in_RegWr = 1'b1; in_wsel = 5'(i + 1);
         in_Branch = vecs[i].branch; in_beq = vecs[i].beq; in_bne = vecs[i].bne;
         in_zero = vecs[i].zero; in_jump = vecs[i].jump; in_jr = vecs[i].jr; in_lui = vecs[i].lui;
         in_rdat1 = vecs[i].rdat1; in_JumpAddr = vecs[i].jaddr; in_BranchAddr = vecs[i].baddr;
         in_PortOut = vecs[i].port_out; in_instr = vecs[i].instr;
         #1;
         check($sformatf("vec%0d_pc_redirect", i), pc_redirect, vecs[i].exp_redirect);
         check($sformatf("vec%0d_redirect_pc", i), redirect_pc, vecs[i].exp_pc);
         tick();
         check($sformatf("vec%0d_wb_result", i), wb_result, vecs[i].exp_result);
         check($sformatf("vec%0d_wb_wsel", i),   wb_wsel,   i + 1);
      end

      // lw, dhit on the third cycle with ihit: two stall cycles then load lands
      clear_inputs();
      ihit = 1'b1; in_MemRead = 1'b1; in_MemToReg = 1'b1; in_RegWr = 1'b1;
      in_wsel = 5'd5; in_PortOut = 32'h100;
      #1;
      check("lw_dmemREN",   bus.dmemREN,  1);
      check("lw_dmemaddr",  bus.dmemaddr, 32'h100);
      check("lw_stall_c1",  mem_stall,    1);
      tick();
      check("lw_stall_c2",  mem_stall,    1);
      check("lw_wb_hold_c2", wb_result,   0);
      tick();
      bus.dhit = 1'b1; bus.dmemload = 32'hDEADBEEF;
      #1;
      check("lw_stall_c3",  mem_stall,    0);
      tick();
      check("lw_wb_load",     wb_load,     32'hDEADBEEF);
      check("lw_wb_MemToReg", wb_MemToReg, 1);
      check("lw_wb_result",   wb_result,   32'h100);
      check("lw_wb_wsel",     wb_wsel,     5);

      // lw hit while fetch is stalled: load must come from the held copy
      clear_inputs();
      in_MemRead = 1'b1; in_RegWr = 1'b1; in_PortOut = 32'h200;
      bus.dhit = 1'b1; bus.dmemload = 32'hCAFEF00D;
      #1;
      check("lwhold_stall_hit", mem_stall, 0);
      tick();
      bus.dhit = 1'b0; bus.dmemload = 32'h0BADBAD0;
      #1;
      check("lwhold_dmemREN_hold", bus.dmemREN, 0);
      check("lwhold_stall_hold",   mem_stall,   0);
      ihit = 1'b1;
      tick();
      check("lwhold_wb_load",   wb_load,   32'hCAFEF00D);
      check("lwhold_wb_result", wb_result, 32'h200);

      // sw, dhit with ihit low for two cycles then ihit
      clear_inputs();
      in_MemWrite = 1'b1; in_rdat2 = 32'h12345678; in_PortOut = 32'h104;
      bus.dhit = 1'b1;
      #1;
      check("sw_dmemWEN",   bus.dmemWEN,   1);
      check("sw_dmemstore", bus.dmemstore, 32'h12345678);
      tick();
      #1;
      check("sw_dmemWEN_hold", bus.dmemWEN, 0);
      check("sw_wb_held_1",    wb_result,   32'h200);
      tick();
      check("sw_wb_held_2",    wb_result,   32'h200);
      ihit = 1'b1; bus.dhit = 1'b0;
      tick();
      check("sw_wb_result", wb_result, 32'h104);
      check("sw_wb_RegWr",  wb_RegWr,  0);
      #1;
      check("sw_idle_dmemWEN", bus.dmemWEN, 1);

      // Populate MEM/WB, then stall in BUSY and pulse reset asynchronously
      clear_inputs();
      ihit = 1'b1; in_RegWr = 1'b1; in_jal = 1'b1; in_wsel = 5'd9;
      in_PortOut = 32'hA5A5; in_npc = 32'h1234; in_instr = 32'h0C000123;
      bus.dmemload = 32'h5555AAAA;
      tick();
      check("pre_wb_jal",   wb_jal,   1);
      check("pre_wb_npc",   wb_npc,   32'h1234);
      check("pre_wb_instr", wb_instr, 32'h0C000123);
      check("pre_wb_load",  wb_load,  32'h5555AAAA);
      clear_inputs();
      ihit = 1'b1; in_MemRead = 1'b1; in_PortOut = 32'h300;
      for (int i = 0; i < 8; i++) tick();
      check("busy_wb_held",     wb_result,   32'hA5A5);
      check("busy_stall",       mem_stall,   1);
      check("wdog_before_trip", mem_timeout, 0);
      tick();
      check("wdog_after_trip",  mem_timeout, WDOG_ON);
      nRST = 1'b0;
      #2;
      check_wb_zero("async_reset");
      check("async_reset_timeout", mem_timeout, 0);
      nRST = 1'b1;
      #1;
      check("post_reset_dmemREN", bus.dmemREN, 1);
      check("post_reset_stall",   mem_stall,   1);

      // Sticky halt survives a flush bubble and blocks cache requests
      clear_inputs();
      tick();
      ihit = 1'b1; in_halt = 1'b1; in_RegWr = 1'b1; in_wsel = 5'd7; in_PortOut = 32'h77;
      tick();
      check("halt_wb_halt",   wb_halt,   1);
      check("halt_wb_result", wb_result, 32'h77);
      clear_inputs();
      ihit = 1'b1; flush = 1'b1; in_RegWr = 1'b1; in_jal = 1'b1; in_npc = 32'h44;
      in_PortOut = 32'h99; in_wsel = 5'd3; bus.dmemload = 32'h1;
      tick();
      check_wb_zero("flush");
      check("flush_wb_halt", wb_halt, 1);
      clear_inputs();
      in_RegWr = 1'b1; in_PortOut = 32'hBEEF;
      tick();
      check("noadv_wb_result", wb_result, 0);
      in_MemRead = 1'b1; in_MemWrite = 1'b1;
      #1;
      check("halt_dmemREN", bus.dmemREN, 0);
      check("halt_dmemWEN", bus.dmemWEN, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
